// File: rtl/fir_avg_pkg.sv
// fir_avg_pkg -- shared width helpers for the multi-channel moving-average filter.
//   acc_width   : accumulator width that holds the sum of up to 2**max_log2n samples exactly
//   chan_width  : width of a channel index (at least 1 bit)
//   clamp_log2n : limit a window select to the largest supported window
package fir_avg_pkg;

    function automatic int acc_width(input int width, input int max_log2n);
        return width + max_log2n;
    endfunction

    function automatic int chan_width(input int channels);
        return (channels > 1) ? $clog2(channels) : 1;
    endfunction

    function automatic int clamp_log2n(input int sel, input int max_log2n);
        return (sel > max_log2n) ? max_log2n : sel;
    endfunction

endpackage

// File: rtl/fir_avg_lane.sv
// fir_avg_lane -- one channel of the moving-average filter.
// Holds a 2**MAX_LOG2N entry circular sample buffer, write pointer, running
// sum and fill counter.
//   clk, reset : clock, synchronous active-high reset
//   clear_i    : wipe all state (window size change)
//   wr_en_i    : accept data_i this cycle
//   log2n_i    : current (already clamped) log2 of window depth
//   data_i     : signed sample
//   sum_o      : running sum including data_i (valid when data_i is offered)
//   full_o     : window holds N real samples once data_i is accepted
module fir_avg_lane
    import fir_avg_pkg::*;
#(
    parameter int WIDTH     = 24,
    parameter int MAX_LOG2N = 3
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   clear_i,
    input  logic                                   wr_en_i,
    input  logic [$clog2(MAX_LOG2N+1)-1:0]         log2n_i,
    input  logic [WIDTH-1:0]                       data_i,
    output logic [acc_width(WIDTH, MAX_LOG2N)-1:0] sum_o,
    output logic                                   full_o
);
    localparam int MAX_N = 1 << MAX_LOG2N;
    localparam int PW    = MAX_LOG2N;
    localparam int FW    = MAX_LOG2N + 1;
    localparam int AW    = acc_width(WIDTH, MAX_LOG2N);

    logic [WIDTH-1:0]     mem_q [MAX_N];
    logic [PW-1:0]        ptr_q;
    logic [FW-1:0]        fill_q;
    logic signed [AW-1:0] acc_q;

    logic [FW-1:0]        n_val;
    logic [PW-1:0]        old_idx;
    logic signed [AW-1:0] sample;
    logic signed [AW-1:0] oldest;

    assign n_val   = FW'(1) << log2n_i;
    // Entry written N beats ago; when N == MAX_N the low bits of n_val are
    // zero and this is the slot about to be overwritten, which is correct.
    assign old_idx = ptr_q - n_val[PW-1:0];
    assign sample  = {{(AW-WIDTH){data_i[WIDTH-1]}}, data_i};

    // Until the window has N samples the missing entries count as zero.
    always_comb begin
        oldest = '0;
        if (fill_q >= n_val)
            oldest = {{(AW-WIDTH){mem_q[old_idx][WIDTH-1]}}, mem_q[old_idx]};
    end

    assign sum_o  = acc_q + sample - oldest;
    assign full_o = (fill_q + FW'(1)) >= n_val;

    always_ff @(posedge clk) begin
        if (reset || clear_i) begin
            for (int i = 0; i < MAX_N; i++) mem_q[i] <= '0;
            ptr_q  <= '0;
            fill_q <= '0;
            acc_q  <= '0;
        end else if (wr_en_i) begin
            mem_q[ptr_q] <= data_i;
            ptr_q        <= ptr_q + PW'(1);
            acc_q        <= $signed(sum_o);
            if (fill_q < n_val) fill_q <= fill_q + FW'(1);
        end
    end

endmodule

// File: rtl/fir_avg_mc.sv
// fir_avg_mc -- time-multiplexed multi-channel moving-average filter.
// Each accepted sample produces one registered result: the floor average of
// the last N = 2**log2n_sel samples of its channel.
//   clk, reset            : clock, synchronous active-high reset
//   log2n_sel             : window select (clamped to MAX_LOG2N); a change flushes all channels
//   in_valid/in_ready     : input handshake, in_chan/in_data carry the sample
//   out_valid/out_ready   : output handshake, out_chan/out_data/out_full carry the result
module fir_avg_mc
    import fir_avg_pkg::*;
#(
    parameter int WIDTH     = 24,
    parameter int MAX_LOG2N = 3,
    parameter int CHANNELS  = 2
) (
    input  logic                            clk,
    input  logic                            reset,
    input  logic [$clog2(MAX_LOG2N+1)-1:0]  log2n_sel,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  logic [chan_width(CHANNELS)-1:0] in_chan,
    input  logic [WIDTH-1:0]                in_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic [chan_width(CHANNELS)-1:0] out_chan,
    output logic [WIDTH-1:0]                out_data,
    output logic                            out_full
);
    localparam int SW = $clog2(MAX_LOG2N + 1);
    localparam int CW = chan_width(CHANNELS);
    localparam int AW = acc_width(WIDTH, MAX_LOG2N);

    logic [SW-1:0]   log2n_q, log2n_d;
    logic            flush_q, flush_d;
    logic            out_valid_q, out_valid_d;
    logic [CW-1:0]   out_chan_q, out_chan_d;
    logic [WIDTH-1:0] out_data_q, out_data_d;
    logic            out_full_q, out_full_d;

    logic [SW-1:0]   lg;
    logic            accept;
    logic            chan_ok;
    logic [CHANNELS-1:0]         lane_sel;
    logic [CHANNELS-1:0]         lane_full;
    logic [CHANNELS-1:0][AW-1:0] lane_sum;
    logic [AW-1:0]   sum_mux;
    logic            full_mux;

    // Lane state was built with the registered window size, so the datapath
    // uses it too; a new select only takes effect after the flush cycle.
    assign lg       = SW'(clamp_log2n(int'(log2n_q), MAX_LOG2N));
    assign in_ready = !flush_q && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    for (genvar c = 0; c < CHANNELS; c++) begin : g_lane
        assign lane_sel[c] = (in_chan == CW'(c));

        fir_avg_lane #(
            .WIDTH     (WIDTH),
            .MAX_LOG2N (MAX_LOG2N)
        ) u_lane (
            .clk     (clk),
            .reset   (reset),
            .clear_i (flush_q),
            .wr_en_i (accept && lane_sel[c]),
            .log2n_i (lg),
            .data_i  (in_data),
            .sum_o   (lane_sum[c]),
            .full_o  (lane_full[c])
        );
    end

    // Out-of-range channel indices match no lane: accepted, then dropped.
    assign chan_ok = |lane_sel;

    always_comb begin
        sum_mux  = '0;
        full_mux = 1'b0;
        for (int c = 0; c < CHANNELS; c++) begin
            if (lane_sel[c]) begin
                sum_mux  = lane_sum[c];
                full_mux = lane_full[c];
            end
        end
    end

    always_comb begin
        log2n_d     = log2n_sel;
        flush_d     = (log2n_sel != log2n_q);
        out_valid_d = out_valid_q;
        out_chan_d  = out_chan_q;
        out_data_d  = out_data_q;
        out_full_d  = out_full_q;
        if (accept && chan_ok) begin
            out_valid_d = 1'b1;
            out_chan_d  = in_chan;
            out_data_d  = WIDTH'($signed(sum_mux) >>> lg);
            out_full_d  = full_mux;
        end else if (out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            log2n_q     <= log2n_sel;
            flush_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_chan_q  <= '0;
            out_data_q  <= '0;
            out_full_q  <= 1'b0;
        end else begin
            log2n_q     <= log2n_d;
            flush_q     <= flush_d;
            out_valid_q <= out_valid_d;
            out_chan_q  <= out_chan_d;
            out_data_q  <= out_data_d;
            out_full_q  <= out_full_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_chan  = out_chan_q;
    assign out_data  = out_data_q;
    assign out_full  = out_full_q;

endmodule

// File: tb/tb_fir_avg_mc.sv
// tb_fir_avg_mc -- randomized and directed bench for fir_avg_mc against a
// queue-based moving-average model (three channels, so index 3 is out of range).
module tb_fir_avg_mc;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  log2n_sel = 2'd3;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [1:0]  in_chan = '0;
    logic [23:0] in_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [1:0]  out_chan;
    logic [23:0] out_data;
    logic        out_full;

    fir_avg_mc #(.WIDTH(24), .MAX_LOG2N(3), .CHANNELS(3)) dut (
        .clk(clk), .reset(reset), .log2n_sel(log2n_sel),
        .in_valid(in_valid), .in_ready(in_ready), .in_chan(in_chan), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_chan(out_chan),
        .out_data(out_data), .out_full(out_full)
    );

    always #5 clk = ~clk;

    typedef struct { int ch; longint d; bit full; } exp_t;

    int     vectors = 0;
    int     miscompares = 0;
    longint hist [3][$];
    exp_t   expq [$];
    int     sel = 3;
    int     sel_reg_m = 3;
    bit     pend_flush = 0;
    bit     stall_prev = 0;
    logic [1:0]  prev_chan;
    logic [23:0] prev_data;
    logic        prev_full;
    longint last_d [4];
    bit     last_full [4];

    task automatic chk(input string tag, input longint obs, input longint exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic longint floor_div(input longint s, input int n);
        longint q;
        q = s / n;
        if ((s % n) != 0 && s < 0) q = q - 1;
        return q;
    endfunction

    // Window = last N samples since the last flush, zeros where none exist.
    task automatic model_accept(input int ch, input longint d, input int lgm);
        exp_t   e;
        longint s;
        int     n, sz;
        if (ch >= 3) return;
        hist[ch].push_back(d);
        if (hist[ch].size() > 8) void'(hist[ch].pop_front());
        n  = 1 << lgm;
        sz = hist[ch].size();
        s  = 0;
        for (int i = 0; i < n && i < sz; i++) s += hist[ch][sz-1-i];
        e.ch = ch; e.d = floor_div(s, n); e.full = (sz >= n);
        expq.push_back(e);
    endtask

    task automatic clear_model();
        for (int c = 0; c < 3; c++) hist[c].delete();
    endtask

    task automatic beat(input bit v, input int ch, input longint d, input bit ordy);
        bit   flush_now, exp_rdy;
        int   lgm;
        exp_t e;
        @(negedge clk);
        in_valid = v; in_chan = 2'(ch); in_data = 24'(d);
        out_ready = ordy; log2n_sel = 2'(sel);
        #1;
        flush_now  = pend_flush;
        lgm        = (sel_reg_m > 3) ? 3 : sel_reg_m;
        pend_flush = (sel != sel_reg_m);
        sel_reg_m  = sel;
        if (stall_prev) begin
            chk("hold_valid", out_valid, 1);
            chk("hold_chan", out_chan, prev_chan);
            chk("hold_data", $signed(out_data), $signed(prev_data));
            chk("hold_full", out_full, prev_full);
        end
        exp_rdy = !flush_now && (!out_valid || out_ready);
        chk("in_ready", in_ready, exp_rdy);
        if (out_valid && out_ready) begin
            if (expq.size() == 0) chk("spurious_out", out_valid, 0);
            else begin
                e = expq.pop_front();
                chk("out_chan", out_chan, e.ch);
                chk("out_data", $signed(out_data), e.d);
                chk("out_full", out_full, e.full);
                last_d[out_chan] = $signed(out_data);
                last_full[out_chan] = out_full;
            end
        end
        stall_prev = out_valid && !out_ready;
        prev_chan = out_chan; prev_data = out_data; prev_full = out_full;
        if (flush_now) clear_model();
        if (v && exp_rdy) model_accept(ch, d, lgm);
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; log2n_sel = 2'(sel);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_data", out_data, 0);
        chk("rst_out_full", out_full, 0);
        chk("rst_out_chan", out_chan, 0);
        chk("rst_in_ready", in_ready, 1);
        clear_model();
        expq.delete();
        stall_prev = 0; pend_flush = 0; sel_reg_m = sel;
    endtask

    task automatic set_sel(input int s);
        sel = s;
        beat(0, 0, 0, 1);
    endtask

    initial begin
        do_reset();

        // ramp on ch0, N=8
        for (int k = 0; k < 200; k++) beat(1, 0, k, 1);
        beat(0, 0, 0, 1);
        chk("ramp_last", last_d[0], 195);
        chk("ramp_full", last_full[0], 1);

        // window change 3 -> 1 mid-stream: change cycle, then flush cycle
        set_sel(1);
        beat(1, 0, 6, 1);
        beat(1, 0, 6, 1);
        beat(0, 0, 0, 1);
        chk("flush_first", last_d[0], 3);
        chk("flush_full", last_full[0], 0);

        // N=4, interleaved constants
        set_sel(2);
        beat(0, 0, 0, 1);
        for (int k = 0; k < 8; k++) begin
            beat(1, 0, -5, 1);
            beat(1, 1, 1000, 1);
        end
        beat(0, 0, 0, 1);
        chk("ch0_const", last_d[0], -5);
        chk("ch1_const", last_d[1], 1000);

        // full-scale, N=8
        set_sel(3);
        beat(0, 0, 0, 1);
        for (int k = 0; k < 8; k++) beat(1, 1, 8388607, 1);
        beat(0, 0, 0, 1);
        chk("fs_pos", last_d[1], 8388607);
        for (int k = 0; k < 8; k++) beat(1, 1, -8388608, 1);
        beat(0, 0, 0, 1);
        chk("fs_neg", last_d[1], -8388608);

        // randomized: 1010 backpressure first, then random everything
        for (int k = 0; k < 1500; k++) begin
            if (k >= 300 && $urandom_range(0, 99) == 0) begin
                set_sel($urandom_range(0, 3));
            end else begin
                beat($urandom_range(0, 3) != 0, $urandom_range(0, 3),
                     $signed(24'($urandom)),
                     (k < 300) ? ((k % 2) == 0) : ($urandom_range(0, 2) != 0));
            end
        end

        // reset while a result is stalled, then N=2 with three 8s
        beat(1, 0, 5, 0);
        beat(0, 0, 0, 0);
        chk("pre_rst_valid", out_valid, 1);
        sel = 1;
        do_reset();
        for (int k = 0; k < 3; k++) beat(1, 0, 8, 1);
        beat(0, 0, 0, 1);
        chk("post_rst_third", last_d[0], 8);
        chk("post_rst_full", last_full[0], 1);

        for (int k = 0; k < 4; k++) beat(0, 0, 0, 1);
        chk("drain_empty", expq.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/fir_avg_mc.md
FIR_AVG_MC -- requirements
Module: fir_avg_mc

Interface
REQ-001 Parameter WIDTH, default 24, signed sample width in bits.
REQ-002 Parameter MAX_LOG2N, default 3, log2 of the maximum window depth (MAX_N = 2**MAX_LOG2N).
REQ-003 Parameter CHANNELS, default 2, number of independent time-multiplexed channels (>=1).
REQ-004 clk  input  1  clock; all state updates on the rising edge.
REQ-005 reset  input  1  reset, synchronous, active-high.
REQ-006 log2n_sel  input  $clog2(MAX_LOG2N+1)  window select; N = 2**log2n_sel, values above MAX_LOG2N clamp to MAX_LOG2N.
REQ-007 in_valid  input  1  in_data/in_chan hold a sample.
REQ-008 in_ready  output  1  block accepts a sample this cycle.
REQ-009 in_chan  input  max(1,$clog2(CHANNELS))  channel index of the sample.
REQ-010 in_data  input  WIDTH  signed sample.
REQ-011 out_valid  output  1  out_* hold a result.
REQ-012 out_ready  input  1  downstream accepts the result.
REQ-013 out_chan  output  as in_chan  channel of the result.
REQ-014 out_data  output  WIDTH  signed average of the last N samples of out_chan.
REQ-015 out_full  output  1  window of out_chan contained N real samples when this result was produced.

Function
REQ-016 Transfer on an input beat occurs when in_valid && in_ready; on the output when out_valid && out_ready.
REQ-017 in_ready = !flush_pending && (!out_valid || out_ready); combinational pass-through of out_ready is permitted.
REQ-018 Each channel keeps a MAX_N-entry circular buffer of full-precision samples, a write pointer and a signed accumulator of WIDTH+MAX_LOG2N bits.
REQ-019 On an accepted beat for channel c: acc_c <= acc_c + in_data - oldest, where oldest is the entry written N beats earlier for c; the sample is written at ptr_c, and ptr_c increments modulo MAX_N.
REQ-020 Accumulator arithmetic is exact; overflow is impossible by width.
REQ-021 out_data = (acc_c + in_data - oldest) >>> log2n_sel (arithmetic shift, truncation toward minus infinity), registered; latency exactly 1 cycle from the accepting edge.
REQ-022 Out-of-range in_chan (>= CHANNELS) is accepted and dropped: no state change, no output.
REQ-023 Fill counter per channel saturates at N; out_full = 1 if the count after the beat is >= N.
REQ-024 Before the window fills, missing entries read as 0 (output = partial sum / N).
REQ-025 A change of log2n_sel from its registered value sets flush_pending: the next cycle clears all buffers, accumulators, pointers and fill counters, in_ready is 0 during that cycle, and the pending output register is kept.
REQ-026 With out_valid=1 and out_ready=0, out_* hold stable.
REQ-027 Simultaneous output drain and new input acceptance in one cycle is supported (full throughput, one sample per cycle).
REQ-028 Channels are fully independent; samples of one channel never affect another.

Reset
REQ-029 Reset clears out_valid, out_full, out_data, out_chan, all buffers, accumulators, pointers and fill counters to 0, and flush_pending to 0; registered log2n_sel is loaded from the port.
REQ-030 Reset asserted mid-stream discards any pending output; the first post-reset result behaves as for a fresh block.

Structure
REQ-031 Package fir_avg_pkg holds the acc width function, the channel-index width function and the clamp-to-MAX_LOG2N helper.
REQ-032 Sub-module fir_avg_lane implements one channel (buffer, pointer, accumulator, fill counter, clear input) and is instantiated CHANNELS times; fir_avg_mc holds the handshake, the channel demux/mux, the flush control and the output register.

Verification
REQ-033 N=8, ch0 fed 0,1,2,...,199, out_ready=1 -> for sample k>=7, out_data = floor((8k-28)/8) and out_full=1 from the 8th beat.
REQ-034 N=4, ch0 constant -5 and ch1 constant 1000 interleaved -> ch0 outputs -2,-3,-4,-5,... (floor), ch1 outputs 250,500,750,1000, with no crosstalk.
REQ-035 Input stream with out_ready toggling 1010... -> no sample lost or duplicated, out_* stable while stalled, in_ready low whenever out_valid && !out_ready.
REQ-036 Change log2n_sel 3->1 mid-stream -> one in_ready=0 cycle, then windows restart from zero (first output = x/2, out_full=0).
REQ-037 Full-scale input 0x7FFFFF for 8 beats then 0x800000 for 8 beats, N=8 -> outputs reach exactly 8388607, then exactly -8388608, with no wrap.
REQ-038 Reset asserted while out_valid=1 and out_ready=0 -> out_valid=0 the next cycle; after 3 beats of 8 at N=2, the third output is 8.
